// File: rtl/text_fb.sv
// Text-mode framebuffer plus cursor/scroll/frame-counter registers for the 80x25 VGA text path.
// Latency: CPU access acks 1 cycle after the request (max 1 transfer / 2 cycles); video reads ack 1 cycle after each request, 1 word/cycle.
// Backpressure: none; neither port inserts wait states, and every accepted request is acked exactly once.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_*                        classic Wishbone slave: RAM (adr[AWIDTH+2]=0) or registers (=1)
//   vid_*                        pipelined Wishbone slave used by the renderer, read-only
//   cursorpos/mode/color         registered cursor settings for the renderer
module text_fb #(
    parameter int AWIDTH = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_dat_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack,

    input  logic        vid_cyc,
    input  logic        vid_stb,
    input  logic        vid_we,
    input  logic [31:0] vid_adr,
    input  logic [3:0]  vid_sel,
    input  logic [31:0] vid_dat_i,
    output logic [31:0] vid_dat_o,
    output logic        vid_ack,

    output logic [31:0] cursorpos,
    output logic [3:0]  cursormode,
    output logic [23:0] cursorcolor
);

    localparam int DEPTH = 1 << AWIDTH;

    // Character RAM; contents are deliberately not reset.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] cpu_ram_rdata_q;
    logic [31:0] vid_ram_rdata_q;

    // Request decode
    logic              cpu_req;
    logic              cpu_reg_sel;
    logic [AWIDTH-1:0] cpu_waddr;
    logic [2:0]        cpu_ridx;
    logic              ram_we;
    logic              vid_req;
    logic [AWIDTH-1:0] vaddr;
    logic [31:0]       wmask;
    logic [31:0]       reg_cur;
    logic [31:0]       reg_wval;

    // Flops
    logic              cpu_ack_d,     cpu_ack_q;
    logic              cpu_rd_reg_d,  cpu_rd_reg_q;
    logic              cpu_rd_ram_d,  cpu_rd_ram_q;
    logic [31:0]       reg_rdata_d,   reg_rdata_q;
    logic [31:0]       cursorpos_d,   cursorpos_q;
    logic [3:0]        cursormode_d,  cursormode_q;
    logic [23:0]       cursorcolor_d, cursorcolor_q;
    logic [AWIDTH-1:0] base_d,        base_q;
    logic [11:0]       framecnt_d,    framecnt_q;
    logic              vid_cyc_d,     vid_cyc_q;
    logic              vid_ack_d,     vid_ack_q;
    logic              vid_we_d,      vid_we_q;

    // Bits of the bus that carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{vid_sel, cpu_adr[31:AWIDTH+3], cpu_adr[1:0],
                           vid_adr[31:AWIDTH+2], vid_adr[1:0], vid_dat_i[31:12]};

    always_comb begin
        cpu_req       = cpu_cyc & cpu_stb & ~cpu_ack_q;
        cpu_reg_sel   = cpu_adr[AWIDTH+2];
        cpu_waddr     = cpu_adr[AWIDTH+1:2];
        cpu_ridx      = cpu_adr[4:2];

        cursorpos_d   = cursorpos_q;
        cursormode_d  = cursormode_q;
        cursorcolor_d = cursorcolor_q;
        base_d        = base_q;
        framecnt_d    = framecnt_q;

        // Current value of the addressed register, zero-extended; also the
        // starting point for a byte-masked write.
        case (cpu_ridx)
            3'd0:    reg_cur = cursorpos_q;
            3'd1:    reg_cur = {28'd0, cursormode_q};
            3'd2:    reg_cur = {8'd0, cursorcolor_q};
            3'd3:    reg_cur = {{(32-AWIDTH){1'b0}}, base_q};
            3'd4:    reg_cur = {20'd0, framecnt_q};
            default: reg_cur = 32'd0;
        endcase

        wmask    = {{8{cpu_sel[3]}}, {8{cpu_sel[2]}}, {8{cpu_sel[1]}}, {8{cpu_sel[0]}}};
        reg_wval = (reg_cur & ~wmask) | (cpu_dat_i & wmask);

        if (cpu_req && cpu_reg_sel && cpu_we) begin
            case (cpu_ridx)
                3'd0:    cursorpos_d   = reg_wval;
                3'd1:    cursormode_d  = reg_wval[3:0];
                3'd2:    cursorcolor_d = reg_wval[23:0];
                3'd3:    base_d        = reg_wval[AWIDTH-1:0];
                default: ;
            endcase
        end

        cpu_ack_d    = cpu_req;
        cpu_rd_reg_d = cpu_req & cpu_reg_sel & ~cpu_we;
        cpu_rd_ram_d = cpu_req & ~cpu_reg_sel & ~cpu_we;
        // Captured every cycle; only presented on cpu_dat_o alongside a register-read ack.
        reg_rdata_d  = reg_cur;
        ram_we       = cpu_req & ~cpu_reg_sel & cpu_we;

        // Every cycle with cyc&stb is a fresh request; the scroll offset is
        // applied here so each request uses BASE as of its own request edge.
        vid_req   = vid_cyc & vid_stb;
        vid_ack_d = vid_req;
        vid_we_d  = vid_we;
        vaddr     = vid_adr[AWIDTH+1:2] + base_q;
        vid_cyc_d = vid_cyc;

        // Frame counter is sampled only on the opening request of a bus cycle.
        if (vid_req && !vid_cyc_q) begin
            framecnt_d = vid_dat_i[11:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_ack_q     <= 1'b0;
            cpu_rd_reg_q  <= 1'b0;
            cpu_rd_ram_q  <= 1'b0;
            reg_rdata_q   <= 32'd0;
            cursorpos_q   <= 32'd0;
            cursormode_q  <= 4'd0;
            cursorcolor_q <= 24'd0;
            base_q        <= '0;
            framecnt_q    <= 12'd0;
            vid_cyc_q     <= 1'b0;
            vid_ack_q     <= 1'b0;
            vid_we_q      <= 1'b0;
        end else begin
            cpu_ack_q     <= cpu_ack_d;
            cpu_rd_reg_q  <= cpu_rd_reg_d;
            cpu_rd_ram_q  <= cpu_rd_ram_d;
            reg_rdata_q   <= reg_rdata_d;
            cursorpos_q   <= cursorpos_d;
            cursormode_q  <= cursormode_d;
            cursorcolor_q <= cursorcolor_d;
            base_q        <= base_d;
            framecnt_q    <= framecnt_d;
            vid_cyc_q     <= vid_cyc_d;
            vid_ack_q     <= vid_ack_d;
            vid_we_q      <= vid_we_d;
        end
    end

    // Dual-port RAM with synchronous reads. Non-blocking semantics give
    // read-old-data when the video port reads the word the CPU is writing.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && cpu_sel[b]) begin
                ram[cpu_waddr][8*b +: 8] <= cpu_dat_i[8*b +: 8];
            end
        end
        cpu_ram_rdata_q <= ram[cpu_waddr];
        vid_ram_rdata_q <= ram[vaddr];
    end

    // Read data is gated by the (reset) ack-side flags, so both data outputs
    // are zero out of reset and whenever no read is being acknowledged.
    assign cpu_ack     = cpu_ack_q;
    assign cpu_dat_o   = cpu_rd_reg_q ? reg_rdata_q :
                         cpu_rd_ram_q ? cpu_ram_rdata_q : 32'd0;
    assign vid_ack     = vid_ack_q;
    assign vid_dat_o   = (vid_ack_q && !vid_we_q) ? vid_ram_rdata_q : 32'd0;
    assign cursorpos   = cursorpos_q;
    assign cursormode  = cursormode_q;
    assign cursorcolor = cursorcolor_q;

endmodule

// File: tb/tb_text_fb.sv
// Self-checking bench for text_fb: directed scenarios plus randomized traffic
// compared against a word-array/register model of the framebuffer.
module tb_text_fb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_cyc = 0, cpu_stb = 0, cpu_we = 0;
    logic [31:0] cpu_adr = 0;
    logic [3:0]  cpu_sel = 0;
    logic [31:0] cpu_dat_i = 0;
    logic [31:0] cpu_dat_o;
    logic        cpu_ack;
    logic        vid_cyc = 0, vid_stb = 0, vid_we = 0;
    logic [31:0] vid_adr = 0;
    logic [3:0]  vid_sel = 0;
    logic [31:0] vid_dat_i = 0;
    logic [31:0] vid_dat_o;
    logic        vid_ack;
    logic [31:0] cursorpos;
    logic [3:0]  cursormode;
    logic [23:0] cursorcolor;

    text_fb #(.AWIDTH(11)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
        .cpu_sel(cpu_sel), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack),
        .vid_cyc(vid_cyc), .vid_stb(vid_stb), .vid_we(vid_we), .vid_adr(vid_adr),
        .vid_sel(vid_sel), .vid_dat_i(vid_dat_i), .vid_dat_o(vid_dat_o), .vid_ack(vid_ack),
        .cursorpos(cursorpos), .cursormode(cursormode), .cursorcolor(cursorcolor)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain word array and register values.
    logic [31:0] mem_m [2048];
    logic [31:0] m_pos;
    logic [3:0]  m_mode;
    logic [23:0] m_color;
    int          m_base;
    logic [11:0] m_fc;

    logic        obs_ack [$];
    logic [31:0] obs_dat [$];

    function automatic logic [31:0] ram_adr(input int w);
        return 32'(w * 4);
    endfunction

    function automatic logic [31:0] reg_adr(input int r);
        return 32'h0000_2000 | 32'(r * 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_reg(input int r);
        case (r)
            0: return m_pos;
            1: return {28'd0, m_mode};
            2: return {8'd0, m_color};
            3: return 32'(m_base);
            4: return {20'd0, m_fc};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_reg_write(input int r, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        t = merge(model_reg(r), d, s);
        case (r)
            0: m_pos   = t;
            1: m_mode  = t[3:0];
            2: m_color = t[23:0];
            3: m_base  = int'(t[10:0]);
            default: ;
        endcase
    endfunction

    // Single CPU transfer; starts and ends 1 time unit after a rising edge.
    task automatic cpu_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, output logic [31:0] rdata,
                              output logic ack1, output logic ack2);
        cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = adr; cpu_dat_i = dat; cpu_sel = sel;
        @(posedge clk_i); #1;
        ack1 = cpu_ack; rdata = cpu_dat_o;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
        @(posedge clk_i); #1;
        ack2 = cpu_ack;
    endtask

    // Video burst of n requests; records ack/data for the n cycles after each
    // request plus one trailing cycle after the strobe drops.
    task automatic vid_burst(input int start, input int n, input logic we,
                             input logic [11:0] fc_first, input logic [11:0] fc_rest);
        obs_ack.delete(); obs_dat.delete();
        for (int i = 0; i < n; i++) begin
            vid_cyc = 1; vid_stb = 1; vid_we = we;
            vid_adr = ram_adr((start + i) % 2048);
            vid_dat_i = {20'd0, (i == 0) ? fc_first : fc_rest};
            @(posedge clk_i); #1;
            obs_ack.push_back(vid_ack); obs_dat.push_back(vid_dat_o);
        end
        vid_cyc = 0; vid_stb = 0; vid_we = 0;
        @(posedge clk_i); #1;
        obs_ack.push_back(vid_ack); obs_dat.push_back(vid_dat_o);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic a1, a2;
        #3;
        n_total++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        n_total++; if (vid_ack !== 1'b0) $display("FAIL reset_vid_ack got %b want 0", vid_ack); else n_pass++;
        n_total++; if (cpu_dat_o !== 32'd0) $display("FAIL reset_cpu_dat got %h want 0", cpu_dat_o); else n_pass++;
        n_total++; if (vid_dat_o !== 32'd0) $display("FAIL reset_vid_dat got %h want 0", vid_dat_o); else n_pass++;
        n_total++; if ({cursorpos, cursormode, cursorcolor} !== 60'd0)
            $display("FAIL reset_cursor got %h/%h/%h want 0", cursorpos, cursormode, cursorcolor); else n_pass++;
        @(posedge clk_i); #1; rst_i = 0;
        @(posedge clk_i); #1;
        for (int r = 3; r <= 4; r++) begin
            cpu_access(0, reg_adr(r), 0, 4'hF, rd, a1, a2);
            n_total++; if (rd !== 32'd0 || a1 !== 1'b1) $display("FAIL reset_reg%0d got %h ack %b want 0 ack 1", r, rd, a1); else n_pass++;
        end
    endtask

    task automatic test_cpu_ram();
        logic [31:0] rd; logic a1, a2;
        cpu_access(1, ram_adr(5), 32'h1F41_2E42, 4'hF, rd, a1, a2);
        mem_m[5] = 32'h1F41_2E42;
        n_total++; if ({a1, a2} !== 2'b10) $display("FAIL cpu_wr_ack got %b want 10", {a1, a2}); else n_pass++;
        cpu_access(0, ram_adr(5), 0, 4'hF, rd, a1, a2);
        n_total++; if ({a1, a2} !== 2'b10) $display("FAIL cpu_rd_ack got %b want 10", {a1, a2}); else n_pass++;
        n_total++; if (rd !== mem_m[5]) $display("FAIL cpu_rd_data got %h want %h", rd, mem_m[5]); else n_pass++;
    endtask

    task automatic test_byte_sel();
        logic [31:0] rd; logic a1, a2;
        cpu_access(1, ram_adr(9), 32'd0, 4'hF, rd, a1, a2);
        cpu_access(1, ram_adr(9), 32'hAABBCCDD, 4'b0101, rd, a1, a2);
        mem_m[9] = 32'h00BB00DD;
        cpu_access(0, ram_adr(9), 0, 4'hF, rd, a1, a2);
        n_total++; if (rd !== mem_m[9]) $display("FAIL byte_sel got %h want %h", rd, mem_m[9]); else n_pass++;
    endtask

    task automatic test_preload();
        logic [31:0] rd; logic a1, a2; int bad = 0;
        for (int w = 0; w < 2048; w++) begin
            mem_m[w] = (w < 40) ? 32'(w) : $urandom;
            cpu_access(1, ram_adr(w), mem_m[w], 4'hF, rd, a1, a2);
            if (a1 !== 1'b1 || a2 !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL preload_acks got %0d bad want 0", bad); else n_pass++;
    endtask

    task automatic test_vid_burst40();
        int bad = 0;
        vid_burst(0, 40, 0, 12'h0, 12'h0);
        for (int i = 0; i < 40; i++)
            if (obs_ack[i] !== 1'b1 || obs_dat[i] !== 32'(i)) bad++;
        n_total++; if (obs_ack[0] !== 1'b1 || obs_dat[0] !== 32'd0)
            $display("FAIL burst40_first got ack %b dat %h want 1/0", obs_ack[0], obs_dat[0]); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL burst40_words got %0d bad want 0", bad); else n_pass++;
        n_total++; if (obs_ack[40] !== 1'b0) $display("FAIL burst40_extra_ack got %b want 0", obs_ack[40]); else n_pass++;
    endtask

    task automatic test_base_wrap();
        logic [31:0] rd; logic a1, a2; int bad = 0;
        cpu_access(1, reg_adr(3), 32'd2045, 4'hF, rd, a1, a2);
        model_reg_write(3, 32'd2045, 4'hF);
        vid_burst(0, 5, 0, 12'h0, 12'h0);
        for (int i = 0; i < 5; i++)
            if (obs_ack[i] !== 1'b1 || obs_dat[i] !== mem_m[(i + 2045) % 2048]) begin
                bad++;
                $display("FAIL base_wrap word %0d got %h want %h", i, obs_dat[i], mem_m[(i + 2045) % 2048]);
            end
        n_total++; if (bad !== 0) $display("FAIL base_wrap got %0d bad want 0", bad); else n_pass++;
        cpu_access(1, reg_adr(3), 32'd0, 4'hF, rd, a1, a2);
        model_reg_write(3, 32'd0, 4'hF);
    endtask

    task automatic test_framecnt();
        logic [31:0] rd; logic a1, a2;
        vid_burst(10, 3, 0, 12'h123, 12'hABC);
        m_fc = 12'h123;
        cpu_access(0, reg_adr(4), 0, 4'hF, rd, a1, a2);
        n_total++; if (rd !== model_reg(4)) $display("FAIL framecnt_1 got %h want %h", rd, model_reg(4)); else n_pass++;
        vid_burst(20, 4, 0, 12'h124, 12'h555);
        m_fc = 12'h124;
        cpu_access(1, reg_adr(4), 32'hFFFF_FFFF, 4'hF, rd, a1, a2);
        cpu_access(0, reg_adr(4), 0, 4'hF, rd, a1, a2);
        n_total++; if (rd !== model_reg(4)) $display("FAIL framecnt_2 got %h want %h", rd, model_reg(4)); else n_pass++;
    endtask

    task automatic test_regs_random();
        logic [31:0] rd, d; logic a1, a2; logic [3:0] s; int r;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 7); d = $urandom; s = 4'($urandom_range(0, 15));
            cpu_access(1, reg_adr(r), d, s, rd, a1, a2);
            model_reg_write(r, d, s);
            n_total++; if ({cursorpos, cursormode, cursorcolor} !== {m_pos, m_mode, m_color})
                $display("FAIL reg_outputs got %h/%h/%h want %h/%h/%h", cursorpos, cursormode, cursorcolor,
                         m_pos, m_mode, m_color); else n_pass++;
            cpu_access(0, reg_adr(r), 0, 4'hF, rd, a1, a2);
            n_total++; if (rd !== model_reg(r)) $display("FAIL reg%0d_readback got %h want %h", r, rd, model_reg(r)); else n_pass++;
        end
    endtask

    task automatic test_vid_random();
        logic [31:0] rd; logic a1, a2; int start, n, bad; logic we;
        for (int k = 0; k < 12; k++) begin
            m_base = $urandom_range(0, 2047);
            cpu_access(1, reg_adr(3), 32'(m_base), 4'hF, rd, a1, a2);
            start = $urandom_range(0, 2047); n = $urandom_range(1, 16); we = ($urandom_range(0, 3) == 0);
            vid_burst(start, n, we, 12'h0, 12'h0);
            bad = 0;
            for (int i = 0; i < n; i++)
                if (obs_ack[i] !== 1'b1 || obs_dat[i] !== (we ? 32'd0 : mem_m[(start + i + m_base) % 2048])) bad++;
            if (obs_ack[n] !== 1'b0) bad++;
            n_total++; if (bad !== 0) $display("FAIL vid_random burst %0d got %0d bad want 0", k, bad); else n_pass++;
        end
        m_base = 0;
        cpu_access(1, reg_adr(3), 32'd0, 4'hF, rd, a1, a2);
    endtask

    task automatic test_cpu_throughput();
        int bad = 0;
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_adr = ram_adr(7); cpu_sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            if (cpu_ack !== (k % 2 == 0)) bad++;
            if (k % 2 == 0 && cpu_dat_o !== mem_m[7]) bad++;
        end
        cpu_cyc = 0; cpu_stb = 0;
        @(posedge clk_i); #1;
        n_total++; if (bad !== 0) $display("FAIL cpu_throughput got %0d bad want 0", bad); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] oldw, neww;
        oldw = mem_m[100]; neww = ~oldw;
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 1; cpu_adr = ram_adr(100); cpu_dat_i = neww; cpu_sel = 4'hF;
        vid_cyc = 1; vid_stb = 1; vid_we = 0; vid_adr = ram_adr(100);
        @(posedge clk_i); #1;
        mem_m[100] = neww;
        n_total++; if (vid_ack !== 1'b1 || vid_dat_o !== oldw)
            $display("FAIL collision_old got ack %b %h want 1 %h", vid_ack, vid_dat_o, oldw); else n_pass++;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; vid_cyc = 0; vid_stb = 0;
        @(posedge clk_i); #1;
        vid_burst(100, 1, 0, 12'h0, 12'h0);
        n_total++; if (obs_dat[0] !== mem_m[100]) $display("FAIL collision_new got %h want %h", obs_dat[0], mem_m[100]); else n_pass++;
    endtask

    task automatic test_reset_midburst();
        logic [31:0] rd; logic a1, a2; int stale = 0; int bad = 0;
        cpu_access(1, reg_adr(2), 32'hFFFF_FFFF, 4'hF, rd, a1, a2);
        model_reg_write(2, 32'hFFFF_FFFF, 4'hF);
        n_total++; if (cursorcolor !== 24'hFF_FFFF) $display("FAIL color_pre_reset got %h want ffffff", cursorcolor); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            vid_cyc = 1; vid_stb = 1; vid_adr = ram_adr(i);
            @(posedge clk_i); #1;
        end
        #2 rst_i = 1;
        #1;
        n_total++; if (vid_ack !== 1'b0 || vid_dat_o !== 32'd0)
            $display("FAIL reset_async_ack got %b %h want 0 0", vid_ack, vid_dat_o); else n_pass++;
        n_total++; if ({cursorpos, cursormode, cursorcolor} !== 60'd0)
            $display("FAIL reset_async_regs got %h/%h/%h want 0", cursorpos, cursormode, cursorcolor); else n_pass++;
        m_pos = 0; m_mode = 0; m_color = 0; m_base = 0; m_fc = 0;
        @(posedge clk_i); #1;
        vid_cyc = 0; vid_stb = 0;
        @(posedge clk_i); #1; rst_i = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            if (vid_ack !== 1'b0) stale++;
        end
        n_total++; if (stale !== 0) $display("FAIL stale_acks got %0d want 0", stale); else n_pass++;
        for (int r = 0; r < 5; r++) begin
            cpu_access(0, reg_adr(r), 0, 4'hF, rd, a1, a2);
            if (rd !== model_reg(r)) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL regs_after_reset got %0d nonzero want 0", bad); else n_pass++;
        vid_burst(30, 3, 0, 12'h0, 12'h0);
        n_total++; if (obs_ack[2] !== 1'b1 || obs_dat[2] !== mem_m[32] || obs_ack[3] !== 1'b0)
            $display("FAIL post_reset_burst got %b %h want 1 %h", obs_ack[2], obs_dat[2], mem_m[32]); else n_pass++;
    endtask

    initial begin
        m_pos = 0; m_mode = 0; m_color = 0; m_base = 0; m_fc = 0;
        test_reset();
        test_cpu_ram();
        test_byte_sel();
        test_preload();
        test_vid_burst40();
        test_base_wrap();
        test_framecnt();
        test_regs_random();
        test_vid_random();
        test_cpu_throughput();
        test_collision();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
